// File: rtl/doorlock_pkg.sv
// -----------------------------------------------------------------------------
// doorlock_pkg
// Shared definitions for the door-lock keypad path:
//   - key codes delivered to the lock controller (KEY_0..KEY_9, KEY_STAR,
//     KEY_HASH, KEY_NONE)
//   - keypad debounce FSM state encoding
//   - frame-result encoding produced by the scanner for the debouncer
//   - key_at(): maps a (row, column) position on the 4x3 matrix to a key code
// -----------------------------------------------------------------------------
package doorlock_pkg;

  // Key codes as seen by the password-entry FSM.
  localparam logic [3:0] KEY_0    = 4'd0;
  localparam logic [3:0] KEY_1    = 4'd1;
  localparam logic [3:0] KEY_2    = 4'd2;
  localparam logic [3:0] KEY_3    = 4'd3;
  localparam logic [3:0] KEY_4    = 4'd4;
  localparam logic [3:0] KEY_5    = 4'd5;
  localparam logic [3:0] KEY_6    = 4'd6;
  localparam logic [3:0] KEY_7    = 4'd7;
  localparam logic [3:0] KEY_8    = 4'd8;
  localparam logic [3:0] KEY_9    = 4'd9;
  localparam logic [3:0] KEY_STAR = 4'd10;
  localparam logic [3:0] KEY_HASH = 4'd11;
  localparam logic [3:0] KEY_NONE = 4'hF;

  // Keypad debounce FSM states.
  localparam logic [1:0] KP_IDLE     = 2'd0;
  localparam logic [1:0] KP_DEBOUNCE = 2'd1;
  localparam logic [1:0] KP_PRESSED  = 2'd2;
  localparam logic [1:0] KP_RELEASE  = 2'd3;

  // Outcome of one full scan frame (three column periods).
  typedef enum logic [1:0] {
    FR_NONE   = 2'd0,  // frame contained zero asserted row bits
    FR_SINGLE = 2'd1,  // exactly one row bit seen
    FR_MULTI  = 2'd2   // two or more row bits seen
  } frame_res_t;

  // Row 0 is the top row, column 0 the left column.
  function automatic logic [3:0] key_at(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    k = KEY_NONE;
    case ({r, c})
      4'b00_00: k = KEY_1;
      4'b00_01: k = KEY_2;
      4'b00_10: k = KEY_3;
      4'b01_00: k = KEY_4;
      4'b01_01: k = KEY_5;
      4'b01_10: k = KEY_6;
      4'b10_00: k = KEY_7;
      4'b10_01: k = KEY_8;
      4'b10_10: k = KEY_9;
      4'b11_00: k = KEY_STAR;
      4'b11_01: k = KEY_0;
      4'b11_10: k = KEY_HASH;
      default:  k = KEY_NONE;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// -----------------------------------------------------------------------------
// keypad_debounce
// Frame-level debounce FSM for the keypad. Only acts on frame-end cycles.
// A key is accepted after DEB_SCANS consecutive frames that each saw exactly
// the same single key; it is released after DEB_SCANS consecutive empty frames.
// Ports:
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   i_frame_end  in   one-cycle strobe: i_frame_res/i_frame_code are valid
//   i_frame_res  in   frame outcome (frame_res_t encoding)
//   i_frame_code in   key code of the single key when i_frame_res==FR_SINGLE
//   o_key_code   out  last accepted key code (KEY_NONE after reset)
//   o_key_valid  out  one-cycle pulse in the cycle o_key_code takes a new key
//   o_key_held   out  high while the accepted key is considered down
// -----------------------------------------------------------------------------
module keypad_debounce
  import doorlock_pkg::*;
#(
  parameter int DEB_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_frame_end,
  input  logic [1:0] i_frame_res,
  input  logic [3:0] i_frame_code,
  output logic [3:0] o_key_code,
  output logic       o_key_valid,
  output logic       o_key_held
);

  localparam int CW = $clog2(DEB_SCANS + 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_TOP = CW'(DEB_SCANS);

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_cand;
  logic [3:0]    r_key_code;
  logic          r_key_valid;

  logic          w_single;
  logic          w_none;
  logic [CW-1:0] w_cnt_inc;

  assign w_single = (i_frame_res == FR_SINGLE);
  assign w_none   = (i_frame_res == FR_NONE);

  // Saturating increment: the counter never wraps even if left in a state
  // longer than expected.
  assign w_cnt_inc = (r_cnt == CNT_TOP) ? r_cnt : r_cnt + CNT_ONE;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= KP_IDLE;
      r_cnt       <= '0;
      r_cand      <= KEY_NONE;
      r_key_code  <= KEY_NONE;
      r_key_valid <= 1'b0;
    end else begin
      // The pulse lives for exactly one cycle after an accepting frame end.
      r_key_valid <= 1'b0;
      if (i_frame_end) begin
        case (r_state)
          KP_IDLE: begin
            if (w_single) begin
              r_cand <= i_frame_code;
              r_cnt  <= CNT_ONE;
              if (DEB_SCANS == 1) begin
                r_key_code  <= i_frame_code;
                r_key_valid <= 1'b1;
                r_state     <= KP_PRESSED;
              end else begin
                r_state <= KP_DEBOUNCE;
              end
            end
          end

          KP_DEBOUNCE: begin
            if (w_single) begin
              if (i_frame_code == r_cand) begin
                r_cnt <= w_cnt_inc;
                if (w_cnt_inc == CNT_TOP) begin
                  r_key_code  <= r_cand;
                  r_key_valid <= 1'b1;
                  r_state     <= KP_PRESSED;
                end
              end else begin
                // A different single key restarts the run on the new key.
                r_cand <= i_frame_code;
                r_cnt  <= CNT_ONE;
              end
            end else begin
              r_cnt   <= '0;
              r_state <= KP_IDLE;
            end
          end

          KP_PRESSED: begin
            // Any activity (including rollover / second keys) keeps the key
            // down without generating a new event.
            if (w_none) begin
              if (DEB_SCANS == 1) begin
                r_cnt   <= '0;
                r_state <= KP_IDLE;
              end else begin
                r_cnt   <= CNT_ONE;
                r_state <= KP_RELEASE;
              end
            end
          end

          KP_RELEASE: begin
            if (w_none) begin
              if (w_cnt_inc == CNT_TOP) begin
                r_cnt   <= '0;
                r_state <= KP_IDLE;
              end else begin
                r_cnt <= w_cnt_inc;
              end
            end else begin
              // Bounce during release: still the same press.
              r_state <= KP_PRESSED;
            end
          end

          default: begin
            r_cnt   <= '0;
            r_state <= KP_IDLE;
          end
        endcase
      end
    end
  end

  assign o_key_code  = r_key_code;
  assign o_key_valid = r_key_valid;
  assign o_key_held  = (r_state == KP_PRESSED) || (r_state == KP_RELEASE);

endmodule

// File: rtl/keypad_scan.sv
// -----------------------------------------------------------------------------
// keypad_scan
// 4-row x 3-column matrix keypad reader for the door lock. Strobes one column
// at a time, samples the rows at the end of each column period, folds three
// column samples into one frame result and hands it to keypad_debounce.
//
// Output handshake: key_valid is a single-cycle strobe with no back-pressure;
// key_code is valid in that cycle and keeps its value until the next strobe.
// The consumer must take the code in the strobe cycle (or read the held
// key_code later, which is stable).
//
// Ports:
//   clk        in   system clock (only clock)
//   rst        in   synchronous active-high reset
//   row[3:0]   in   row sense, active-high, row[0] = top row
//   col[2:0]   out  one-hot column strobe, active-high, col[0] = left column
//   key_code   out  last accepted key (KEY_NONE after reset)
//   key_valid  out  one-cycle pulse when key_code is updated
//   key_held   out  high while an accepted key is considered down
// Parameters:
//   SCAN_DIV   clk cycles per column period (>= 2)
//   DEB_SCANS  consecutive identical frames to accept a press or release (>= 1)
// -----------------------------------------------------------------------------
module keypad_scan
  import doorlock_pkg::*;
#(
  parameter int SCAN_DIV  = 1000,
  parameter int DEB_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [2:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] PRESC_ONE  = PW'(1);

  logic [PW-1:0] r_presc;
  logic [2:0]    r_col;
  logic [1:0]    r_acc_cnt;   // saturating count of row bits seen this frame
  logic [3:0]    r_acc_code;  // code of the most recent single-bit sample

  logic       w_tick;
  logic       w_frame_end;
  logic [2:0] w_row_bits;
  logic [1:0] w_row_sat;
  logic [1:0] w_row_idx;
  logic [1:0] w_col_idx;
  logic [3:0] w_sample_code;
  logic [2:0] w_acc_sum;
  logic [1:0] w_acc_next;
  logic [3:0] w_acc_code_next;
  logic [1:0] w_frame_res;

  // ---------------------------------------------------------------------------
  // Prescaler and column strobe
  // ---------------------------------------------------------------------------
  assign w_tick      = (r_presc == PRESC_LAST);
  // The last column period of a frame is the one driving col[2].
  assign w_frame_end = w_tick & r_col[2];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PRESC_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col <= 3'b001;
    end else if (w_tick) begin
      r_col <= {r_col[1:0], r_col[2]};
    end
  end

  // ---------------------------------------------------------------------------
  // Row sample decode. Rows are only looked at on w_tick, the last cycle of the
  // column period, so the row lines have had the whole period to settle.
  // ---------------------------------------------------------------------------
  assign w_row_bits = {2'b00, row[0]} + {2'b00, row[1]}
                    + {2'b00, row[2]} + {2'b00, row[3]};
  assign w_row_sat  = (w_row_bits >= 3'd2) ? 2'd2 : w_row_bits[1:0];

  // Index decoders only matter when exactly one bit is set.
  assign w_row_idx = row[0] ? 2'd0 :
                     row[1] ? 2'd1 :
                     row[2] ? 2'd2 : 2'd3;
  assign w_col_idx = r_col[0] ? 2'd0 :
                     r_col[1] ? 2'd1 : 2'd2;

  assign w_sample_code = key_at(w_row_idx, w_col_idx);

  // ---------------------------------------------------------------------------
  // Frame accumulator. The frame result includes the sample taken on the
  // frame-end tick itself, so it is formed from the "next" accumulator value.
  // ---------------------------------------------------------------------------
  assign w_acc_sum       = {1'b0, r_acc_cnt} + {1'b0, w_row_sat};
  assign w_acc_next      = (w_acc_sum >= 3'd2) ? 2'd2 : w_acc_sum[1:0];
  // If only one bit is seen in the frame it came from whichever sample had
  // exactly one bit; any further bit turns the frame into MULTI anyway.
  assign w_acc_code_next = (w_row_sat == 2'd1) ? w_sample_code : r_acc_code;

  always_comb begin
    w_frame_res = FR_NONE;
    if (w_acc_next == 2'd1) begin
      w_frame_res = FR_SINGLE;
    end else if (w_acc_next == 2'd2) begin
      w_frame_res = FR_MULTI;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc_cnt  <= '0;
      r_acc_code <= KEY_NONE;
    end else if (w_frame_end) begin
      r_acc_cnt  <= '0;
      r_acc_code <= KEY_NONE;
    end else if (w_tick) begin
      r_acc_cnt  <= w_acc_next;
      r_acc_code <= w_acc_code_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce / event generation
  // ---------------------------------------------------------------------------
  keypad_debounce #(
    .DEB_SCANS (DEB_SCANS)
  ) u_debounce (
    .clk          (clk),
    .rst          (rst),
    .i_frame_end  (w_frame_end),
    .i_frame_res  (w_frame_res),
    .i_frame_code (w_acc_code_next),
    .o_key_code   (key_code),
    .o_key_valid  (key_valid),
    .o_key_held   (key_held)
  );

  assign col = r_col;

endmodule
